// File: rtl/bsg_manycore_host_arb_pkg.sv
// Shared types for the host request arbiter: arbiter state encoding and the
// buffered-beat struct, which is parameterised by field widths through a macro.
package bsg_manycore_host_arb_pkg;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_LOCK = 1'b1
    } arb_state_e;

    localparam int min_data_width_gp = 32;
    localparam int min_num_req_gp    = 2;

endpackage

`ifndef BSG_MANYCORE_HOST_REQ_BEAT_S
`define BSG_MANYCORE_HOST_REQ_BEAT_S
`define BSG_MANYCORE_HOST_REQ_BEAT_S_DECL(dw, aw, xw, yw) typedef struct packed { logic [(dw)-1:0] data; logic [((dw)>>3)-1:0] mask; logic [(aw)-1:0] addr; logic we; logic [(xw)-1:0] src_x; logic [(yw)-1:0] src_y; logic last; } host_req_beat_s
`endif

// File: rtl/bsg_manycore_host_arb_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr_i, wrapping to 0.
module bsg_manycore_host_arb_rr_pick #(
    parameter int num_req_p  = 2,
    parameter int id_width_p = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic [num_req_p-1:0]  req_i,
    input  logic [id_width_p-1:0] ptr_i,
    output logic [num_req_p-1:0]  grant_o,
    output logic [id_width_p-1:0] idx_o,
    output logic                  any_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = (int'(ptr_i) + i) % num_req_p;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                idx_o         = id_width_p'(cand);
                grant_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/bsg_manycore_host_request_arbiter.sv
// Packet-atomic round-robin arbiter sharing one host-bound request channel
// between num_req_p sources, with a single registered output beat.
//
//   state  | meaning
//   E_IDLE | any valid requester may win, scanning from rr_ptr_q
//   E_LOCK | mid-packet; only lock_id_q may issue beats until its last beat
module bsg_manycore_host_request_arbiter
    import bsg_manycore_host_arb_pkg::*;
#(
    parameter int num_req_p       = 2,
    parameter int x_cord_width_p  = 4,
    parameter int y_cord_width_p  = 4,
    parameter int addr_width_p    = 28,
    parameter int data_width_p    = 32,
    parameter int pkt_cnt_width_p = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [num_req_p-1:0]                    v_i,
    input  logic [num_req_p-1:0]                    last_i,
    output logic [num_req_p-1:0]                    yumi_o,
    input  logic [num_req_p*data_width_p-1:0]       data_i,
    input  logic [num_req_p*(data_width_p>>3)-1:0]  mask_i,
    input  logic [num_req_p*addr_width_p-1:0]       addr_i,
    input  logic [num_req_p-1:0]                    we_i,
    input  logic [num_req_p*x_cord_width_p-1:0]     src_x_cord_i,
    input  logic [num_req_p*y_cord_width_p-1:0]     src_y_cord_i,
    output logic                                    v_o,
    input  logic                                    rdy_i,
    output logic [data_width_p-1:0]                 data_o,
    output logic [(data_width_p>>3)-1:0]            mask_o,
    output logic [addr_width_p-1:0]                 addr_o,
    output logic                                    we_o,
    output logic [x_cord_width_p-1:0]               src_x_cord_o,
    output logic [y_cord_width_p-1:0]               src_y_cord_o,
    output logic                                    last_o,
    output logic [$clog2(num_req_p)-1:0]            grant_id_o,
    output logic [pkt_cnt_width_p-1:0]              pkt_cnt_o
);

    localparam int mask_width_lp = data_width_p >> 3;
    localparam int id_width_lp   = $clog2(num_req_p);

    `BSG_MANYCORE_HOST_REQ_BEAT_S_DECL(data_width_p, addr_width_p, x_cord_width_p, y_cord_width_p);

    arb_state_e                 state_q, state_d;
    logic [id_width_lp-1:0]     rr_ptr_q, rr_ptr_d;
    logic [id_width_lp-1:0]     lock_id_q, lock_id_d;
    logic [id_width_lp-1:0]     grant_id_q, grant_id_d;
    logic                       out_v_q, out_v_d;
    host_req_beat_s             beat_q, beat_d;
    logic [pkt_cnt_width_p-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [num_req_p-1:0]   pick_grant;
    logic [id_width_lp-1:0] pick_idx;
    logic                   pick_any;
    logic [num_req_p-1:0]   yumi;
    logic [id_width_lp-1:0] sel_id;
    int                     sel_n;
    logic                   can_load;
    logic                   load;
    logic                   xfer;

    bsg_manycore_host_arb_rr_pick #(
        .num_req_p  (num_req_p),
        .id_width_p (id_width_lp)
    ) u_rr_pick (
        .req_i   (v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        xfer     = out_v_q & rdy_i;
        // Draining and refilling in the same cycle keeps full throughput.
        can_load = ~out_v_q | rdy_i;
        yumi     = '0;
        sel_id   = pick_idx;
        if (state_q == E_LOCK) begin
            sel_id = lock_id_q;
            if (can_load && v_i[lock_id_q]) begin
                yumi[lock_id_q] = 1'b1;
            end
        end else if (can_load && pick_any) begin
            yumi = pick_grant;
        end
        load  = |yumi;
        sel_n = int'(sel_id);

        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        grant_id_d = grant_id_q;
        out_v_d    = out_v_q;
        beat_d     = beat_q;
        pkt_cnt_d  = pkt_cnt_q;

        if (xfer && beat_q.last) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end

        if (load) begin
            out_v_d      = 1'b1;
            grant_id_d   = sel_id;
            beat_d.data  = data_i[sel_n*data_width_p +: data_width_p];
            beat_d.mask  = mask_i[sel_n*mask_width_lp +: mask_width_lp];
            beat_d.addr  = addr_i[sel_n*addr_width_p +: addr_width_p];
            beat_d.we    = we_i[sel_id];
            beat_d.src_x = src_x_cord_i[sel_n*x_cord_width_p +: x_cord_width_p];
            beat_d.src_y = src_y_cord_i[sel_n*y_cord_width_p +: y_cord_width_p];
            beat_d.last  = last_i[sel_id];
            if (last_i[sel_id]) begin
                state_d  = E_IDLE;
                rr_ptr_d = (sel_id == id_width_lp'(num_req_p - 1)) ? '0 : sel_id + 1'b1;
            end else begin
                state_d   = E_LOCK;
                lock_id_d = sel_id;
            end
        end else if (xfer) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= E_IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            grant_id_q <= '0;
            out_v_q    <= 1'b0;
            beat_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            grant_id_q <= grant_id_d;
            out_v_q    <= out_v_d;
            beat_q     <= beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign yumi_o       = reset_i ? '0 : yumi;
    assign v_o          = out_v_q;
    assign data_o       = beat_q.data;
    assign mask_o       = beat_q.mask;
    assign addr_o       = beat_q.addr;
    assign we_o         = beat_q.we;
    assign src_x_cord_o = beat_q.src_x;
    assign src_y_cord_o = beat_q.src_y;
    assign last_o       = beat_q.last;
    assign grant_id_o   = grant_id_q;
    assign pkt_cnt_o    = pkt_cnt_q;

`ifndef SYNTHESIS
    if (data_width_p < min_data_width_gp) begin : g_bad_data_width
        $error("data_width_p must be at least 32");
    end
    if (num_req_p < min_num_req_gp) begin : g_bad_num_req
        $error("num_req_p must be at least 2");
    end

    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_o));
    a_yumi_room:   assert property (@(posedge clk_i) disable iff (reset_i) (|yumi_o) |-> can_load);
`endif

endmodule

// File: tb/tb_bsg_manycore_host_request_arbiter.sv
// Directed bench for the host request arbiter, three requesters, with
// hand-derived expected grant order, data and packet counts.
module tb_bsg_manycore_host_request_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int MW = DW >> 3;
    localparam int AW = 16;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int CW = 32;
    localparam int IW = 2;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    v_i, last_i, yumi_o, we_i;
    logic [N*DW-1:0] data_i;
    logic [N*MW-1:0] mask_i;
    logic [N*AW-1:0] addr_i;
    logic [N*XW-1:0] src_x_cord_i;
    logic [N*YW-1:0] src_y_cord_i;
    logic            v_o, rdy_i, we_o, last_o;
    logic [DW-1:0]   data_o;
    logic [MW-1:0]   mask_o;
    logic [AW-1:0]   addr_o;
    logic [XW-1:0]   src_x_cord_o;
    logic [YW-1:0]   src_y_cord_o;
    logic [IW-1:0]   grant_id_o;
    logic [CW-1:0]   pkt_cnt_o;

    always #5 clk_i = ~clk_i;

    bsg_manycore_host_request_arbiter #(
        .num_req_p       (N),
        .x_cord_width_p  (XW),
        .y_cord_width_p  (YW),
        .addr_width_p    (AW),
        .data_width_p    (DW),
        .pkt_cnt_width_p (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .last_i       (last_i),
        .yumi_o       (yumi_o),
        .data_i       (data_i),
        .mask_i       (mask_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .src_x_cord_i (src_x_cord_i),
        .src_y_cord_i (src_y_cord_i),
        .v_o          (v_o),
        .rdy_i        (rdy_i),
        .data_o       (data_o),
        .mask_o       (mask_o),
        .addr_o       (addr_o),
        .we_o         (we_o),
        .src_x_cord_o (src_x_cord_o),
        .src_y_cord_o (src_y_cord_o),
        .last_o       (last_o),
        .grant_id_o   (grant_id_o),
        .pkt_cnt_o    (pkt_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] s_data [N][16];
    logic        s_last [N][16];
    int          s_cnt  [N];
    int          s_pos  [N];
    logic [N-1:0] s_hold;
    logic [N-1:0] yumi_s;

    logic [1:0]  log_id[$];
    logic [31:0] log_data[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] lid(input int i);
        return (i < log_id.size()) ? 64'(log_id[i]) : 64'hdead;
    endfunction

    function automatic logic [63:0] ldat(input int i);
        return (i < log_data.size()) ? 64'(log_data[i]) : 64'hdead;
    endfunction

    task automatic clr_src();
        for (int k = 0; k < N; k++) begin
            s_cnt[k] = 0;
            s_pos[k] = 0;
        end
        s_hold = '0;
        log_id.delete();
        log_data.delete();
    endtask

    task automatic add(input int k, input logic [31:0] d, input logic l);
        s_data[k][s_cnt[k]] = d;
        s_last[k][s_cnt[k]] = l;
        s_cnt[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (s_pos[k] < 16) ? s_pos[k] : 15;
            v_i[k]                   = (s_pos[k] < s_cnt[k]) && !s_hold[k];
            data_i[k*DW +: DW]       = s_data[k][idx];
            last_i[k]                = s_last[k][idx];
            mask_i[k*MW +: MW]       = '1;
            addr_i[k*AW +: AW]       = AW'(16'h0100 + k);
            we_i[k]                  = 1'b1;
            src_x_cord_i[k*XW +: XW] = XW'(k);
            src_y_cord_i[k*YW +: YW] = YW'(k + 1);
        end
    endtask

    // One clock: drive, sample at negedge, advance sources on consumed beats.
    task automatic cyc();
        drive();
        @(negedge clk_i);
        yumi_s = yumi_o;
        chk("yumi_onehot", 64'($onehot0(yumi_o)), 64'd1);
        chk("yumi_invalid", 64'(yumi_o & ~v_i), 64'd0);
        chk("yumi_full", 64'(v_o && !rdy_i && (|yumi_o)), 64'd0);
        if (v_o && rdy_i) begin
            log_id.push_back(grant_id_o);
            log_data.push_back(data_o);
        end
        @(posedge clk_i);
        #1;
        for (int k = 0; k < N; k++) begin
            if (yumi_s[k]) s_pos[k]++;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 16; j++) begin
                s_data[k][j] = '0;
                s_last[k][j] = 1'b0;
            end
        end
        reset_i = 1'b1;
        rdy_i   = 1'b1;
        clr_src();
        add(0, 32'h1, 1'b1);
        add(1, 32'h2, 1'b1);
        drive();
        #12;
        chk("rst_yumi", 64'(yumi_o), 64'd0);
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt_o), 64'd0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Single-beat packets from req0 and req1: alternate, no bubbles.
        clr_src();
        for (int i = 0; i < 8; i++) begin
            add(0, 32'h0A00 + i, 1'b1);
            add(1, 32'h0B00 + i, 1'b1);
        end
        cyc();
        chk("t1_v_o", 64'(v_o), 64'd1);
        chk("t1_data", 64'(data_o), 64'h0A00);
        chk("t1_grant", 64'(grant_id_o), 64'd0);
        chk("t1_addr", 64'(addr_o), 64'h0100);
        chk("t1_mask", 64'(mask_o), 64'hf);
        chk("t1_we", 64'(we_o), 64'd1);
        chk("t1_src_x", 64'(src_x_cord_o), 64'd0);
        chk("t1_src_y", 64'(src_y_cord_o), 64'd1);
        chk("t1_last", 64'(last_o), 64'd1);
        cycles(8);
        chk("t1_pkt8", 64'(pkt_cnt_o), 64'd8);
        cycles(8);
        chk("t1_len", 64'(log_id.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t1_id", lid(i), 64'(i % 2));
            chk("t1_dat", ldat(i), 64'(((i % 2) ? 32'h0B00 : 32'h0A00) + i / 2));
        end
        chk("t1_pkt16", 64'(pkt_cnt_o), 64'd16);

        // Two-beat timer readout from req0 is not interleaved with req1.
        clr_src();
        add(0, 32'h0000_1234, 1'b0);
        add(0, 32'h0000_0000, 1'b1);
        add(1, 32'h0000_00B1, 1'b1);
        cycles(5);
        chk("t2_len", 64'(log_id.size()), 64'd3);
        chk("t2_id0", lid(0), 64'd0);
        chk("t2_id1", lid(1), 64'd0);
        chk("t2_id2", lid(2), 64'd1);
        chk("t2_d0", ldat(0), 64'h1234);
        chk("t2_d1", ldat(1), 64'h0);
        chk("t2_d2", ldat(2), 64'hB1);
        chk("t2_pkt", 64'(pkt_cnt_o), 64'd18);

        // Host stalls for 5 cycles: beat held stable, no grants.
        clr_src();
        add(0, 32'hA0, 1'b1);
        add(0, 32'hA1, 1'b1);
        add(1, 32'hB0, 1'b1);
        add(1, 32'hB1, 1'b1);
        rdy_i = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_yumi", 64'(yumi_s), 64'd0);
            chk("t3_v_o", 64'(v_o), 64'd1);
            chk("t3_data", 64'(data_o), 64'hA0);
        end
        rdy_i = 1'b1;
        cycles(5);
        chk("t3_len", 64'(log_id.size()), 64'd4);
        chk("t3_d0", ldat(0), 64'hA0);
        chk("t3_d1", ldat(1), 64'hB0);
        chk("t3_d2", ldat(2), 64'hA1);
        chk("t3_d3", ldat(3), 64'hB1);
        chk("t3_pkt", 64'(pkt_cnt_o), 64'd22);

        // Locked req1 bubbles for 3 cycles while req0 waits.
        clr_src();
        add(1, 32'hC0, 1'b0);
        add(1, 32'hC1, 1'b1);
        add(0, 32'hD0, 1'b1);
        s_hold[0] = 1'b1;
        cyc();
        s_hold = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_bubble", 64'(yumi_s), 64'd0);
        end
        s_hold = '0;
        cycles(4);
        chk("t4_len", 64'(log_id.size()), 64'd3);
        chk("t4_id0", lid(0), 64'd1);
        chk("t4_id1", lid(1), 64'd1);
        chk("t4_id2", lid(2), 64'd0);
        chk("t4_d1", ldat(1), 64'hC1);
        chk("t4_d2", ldat(2), 64'hD0);

        // Pointer at 2 with req0 and req2 valid: req2 first, then wrap to req0.
        clr_src();
        add(1, 32'hE0, 1'b1);
        add(0, 32'hF0, 1'b1);
        add(2, 32'h60, 1'b1);
        s_hold = 3'b101;
        cyc();
        s_hold = '0;
        cycles(4);
        chk("t5_len", 64'(log_id.size()), 64'd3);
        chk("t5_id0", lid(0), 64'd1);
        chk("t5_id1", lid(1), 64'd2);
        chk("t5_id2", lid(2), 64'd0);
        // Pointer now 1: req1 beats req0.
        clr_src();
        add(0, 32'h70, 1'b1);
        add(1, 32'h71, 1'b1);
        cycles(4);
        chk("t5_ptr_id0", lid(0), 64'd1);
        chk("t5_ptr_id1", lid(1), 64'd0);
        chk("t5_pkt", 64'(pkt_cnt_o), 64'd29);

        // Asynchronous reset while req2 is locked and a beat is buffered.
        clr_src();
        add(2, 32'h80, 1'b0);
        add(2, 32'h81, 1'b0);
        add(2, 32'h82, 1'b1);
        rdy_i = 1'b0;
        cyc();
        chk("t6_v_pre", 64'(v_o), 64'd1);
        chk("t6_grant_pre", 64'(grant_id_o), 64'd2);
        drive();
        #2;
        reset_i = 1'b1;
        #1;
        chk("t6_v_async", 64'(v_o), 64'd0);
        chk("t6_pkt_async", 64'(pkt_cnt_o), 64'd0);
        chk("t6_yumi_rst", 64'(yumi_o), 64'd0);
        @(posedge clk_i);
        #1;
        clr_src();
        add(0, 32'h90, 1'b1);
        add(1, 32'h91, 1'b1);
        add(2, 32'h92, 1'b1);
        drive();
        @(posedge clk_i);
        #1;
        chk("t6_yumi_rst2", 64'(yumi_o), 64'd0);
        reset_i = 1'b0;
        rdy_i   = 1'b1;
        cycles(5);
        chk("t6_len", 64'(log_id.size()), 64'd3);
        chk("t6_id0", lid(0), 64'd0);
        chk("t6_id1", lid(1), 64'd1);
        chk("t6_id2", lid(2), 64'd2);
        chk("t6_pkt", 64'(pkt_cnt_o), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
